// File: rtl/aircon_pkg.sv
// aircon_pkg: shared types and default thresholds for the HVAC zone scheduler
package aircon_pkg;
    localparam int TEMP_W       = 5;
    localparam int HEAT_ON_DEF  = 18;
    localparam int SETPOINT_DEF = 20;
    localparam int COOL_ON_DEF  = 22;

    typedef enum logic [1:0] {IDLE, RUN, DWELL} state_e;
    typedef enum logic {HEAT, COOL} mode_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request above last_grant
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    logic [IW-1:0] cand;

    // Walk candidates from farthest to nearest so the nearest requester wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last_grant) + k) % N);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/hvac_zone_scheduler.sv
// hvac_zone_scheduler: shares one heat/cool plant across zones with hysteresis and dwell
module hvac_zone_scheduler
    import aircon_pkg::*;
#(
    parameter int N_ZONES   = 4,
    parameter int HEAT_ON   = HEAT_ON_DEF,
    parameter int COOL_ON   = COOL_ON_DEF,
    parameter int SETPOINT  = SETPOINT_DEF,
    parameter int MIN_RUN   = 4,
    parameter int MAX_RUN   = 16,
    parameter int DEAD_TIME = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [TEMP_W*N_ZONES-1:0] zone_temp,
    output logic                      heating,
    output logic                      cooling,
    output logic [N_ZONES-1:0]        zone_sel,
    output logic                      busy
);
    localparam int IW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
    localparam int RW = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;
    localparam int DW = $clog2(DEAD_TIME + 1);

    logic [TEMP_W-1:0]  temps [N_ZONES];
    logic [N_ZONES-1:0] req_heat, req_cool, arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               satisfied;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [IW-1:0]      idx_q, idx_d, last_q, last_d;
    logic [RW-1:0]      run_cnt_q, run_cnt_d;
    logic [DW-1:0]      dwell_cnt_q, dwell_cnt_d;
    logic               heating_q, heating_d, cooling_q, cooling_d, busy_q, busy_d;
    logic [N_ZONES-1:0] zone_sel_q, zone_sel_d;

    // Per-zone demand from unsigned threshold compares
    always_comb begin
        req_heat = '0;
        req_cool = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            temps[i]    = zone_temp[i*TEMP_W +: TEMP_W];
            req_heat[i] = temps[i] <= TEMP_W'(HEAT_ON);
            req_cool[i] = temps[i] >= TEMP_W'(COOL_ON);
        end
    end

    rr_arbiter #(.N(N_ZONES), .IW(IW)) u_arb (
        .req        (req_heat | req_cool),
        .last_grant (last_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    assign satisfied = (mode_q == HEAT) ? temps[idx_q] >= TEMP_W'(SETPOINT)
                                        : temps[idx_q] <= TEMP_W'(SETPOINT);

    // Next-state and registered-output computation for IDLE/RUN/DWELL
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        last_d      = last_q;
        run_cnt_d   = run_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        heating_d   = heating_q;
        cooling_d   = cooling_q;
        zone_sel_d  = zone_sel_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: if (enable && |(req_heat | req_cool)) begin
                state_d    = RUN;
                mode_d     = req_heat[arb_idx] ? HEAT : COOL;
                idx_d      = arb_idx;
                run_cnt_d  = '0;
                heating_d  = req_heat[arb_idx];
                cooling_d  = !req_heat[arb_idx];
                zone_sel_d = arb_grant;
                busy_d     = 1'b1;
            end
            RUN: if (!enable || run_cnt_q == RW'(MAX_RUN - 1) ||
                     (satisfied && run_cnt_q >= RW'(MIN_RUN - 1))) begin
                state_d     = DWELL;
                last_d      = idx_q;
                heating_d   = 1'b0;
                cooling_d   = 1'b0;
                zone_sel_d  = '0;
                dwell_cnt_d = '0;
            end else begin
                run_cnt_d = run_cnt_q + 1'b1;
            end
            DWELL: if (dwell_cnt_q == DW'(DEAD_TIME - 1)) begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                dwell_cnt_d = '0;
            end else begin
                dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= HEAT;
            idx_q       <= '0;
            last_q      <= IW'(N_ZONES - 1);
            run_cnt_q   <= '0;
            dwell_cnt_q <= '0;
            heating_q   <= 1'b0;
            cooling_q   <= 1'b0;
            zone_sel_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            run_cnt_q   <= run_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            heating_q   <= heating_d;
            cooling_q   <= cooling_d;
            zone_sel_q  <= zone_sel_d;
            busy_q      <= busy_d;
        end
    end

    assign heating  = heating_q;
    assign cooling  = cooling_q;
    assign zone_sel = zone_sel_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// tb_hvac_zone_scheduler: directed and random stimulus against a zone-level reference model
module tb_hvac_zone_scheduler;
    localparam int N = 4, MIN_RUN = 4, MAX_RUN = 16, DEAD = 3;

    typedef struct packed {
        logic         h;
        logic         c;
        logic [N-1:0] z;
        logic         b;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b1;
    logic [5*N-1:0] zone_temp = '0;
    logic           heating, cooling, busy;
    logic [N-1:0]   zone_sel;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0, pushed = 0;
    int   owner = -1, last = N - 1, run_cycles = 0, dwell_left = 0;
    bit   heat_mode = 1'b0;

    always #5 clk = ~clk;

    hvac_zone_scheduler #(
        .N_ZONES(N), .MIN_RUN(MIN_RUN), .MAX_RUN(MAX_RUN), .DEAD_TIME(DEAD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .zone_temp(zone_temp),
        .heating(heating), .cooling(cooling), .zone_sel(zone_sel), .busy(busy)
    );

    function automatic int t_of(int z);
        return int'(zone_temp[z*5 +: 5]);
    endfunction

    task automatic set_t(int z, int t);
        zone_temp[z*5 +: 5] = 5'(t);
    endtask

    task automatic set_all(int t);
        for (int z = 0; z < N; z++) set_t(z, t);
    endtask

    function automatic int rand_temp();
        int r = $urandom_range(0, 9);
        case (r)
            0: return 0;
            1: return 31;
            2: return 18;
            3: return 19;
            4: return 20;
            5: return 21;
            6: return 22;
            default: return $urandom_range(0, 31);
        endcase
    endfunction

    // Reference: who owns the plant, for how long it has run, and dwell still owed
    task automatic tick();
        exp_t e;
        if (!rst_n) begin
            owner = -1; last = N - 1; run_cycles = 0; dwell_left = 0;
        end else if (owner >= 0) begin
            int t = t_of(owner);
            bit sat = heat_mode ? (t >= 20) : (t <= 20);
            if (!enable || run_cycles >= MAX_RUN || (sat && run_cycles >= MIN_RUN)) begin
                last = owner; owner = -1; dwell_left = DEAD;
            end else begin
                run_cycles++;
            end
        end else if (dwell_left > 0) begin
            dwell_left--;
        end else if (enable) begin
            for (int k = 1; k <= N; k++) begin
                int z = (last + k) % N;
                int t = t_of(z);
                if (owner < 0 && (t <= 18 || t >= 22)) begin
                    owner = z; heat_mode = (t <= 18); run_cycles = 1;
                end
            end
        end
        e.h = (owner >= 0) && heat_mode;
        e.c = (owner >= 0) && !heat_mode;
        e.z = (owner >= 0) ? N'(1 << owner) : '0;
        e.b = (owner >= 0) || (dwell_left > 0);
        sb.push_back(e);
        pushed++;
        @(negedge clk);
    endtask

    task automatic cyc(int n);
        repeat (n) tick();
    endtask

    // Monitor: compare DUT outputs just after each edge against the queued expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if ({heating, cooling, zone_sel, busy} !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got h=%b c=%b z=%b b=%b expected h=%b c=%b z=%b b=%b",
                         $time, heating, cooling, zone_sel, busy, e.h, e.c, e.z, e.b);
            end
        end
    end

    initial begin
        @(negedge clk);
        // reset with all zones cold, then first grant to zone 0
        rst_n = 0; enable = 1; set_all(15); cyc(2);
        rst_n = 1; cyc(30);
        // single heating zone satisfied quickly: MIN_RUN then dwell
        rst_n = 0; set_all(20); set_t(2, 16); cyc(1);
        rst_n = 1; cyc(1); set_t(2, 20); cyc(12);
        // simultaneous cool and heat demand
        rst_n = 0; set_all(20); set_t(0, 25); set_t(1, 15); cyc(1);
        rst_n = 1; cyc(6); set_t(0, 20); cyc(20);
        // persistent demands: forced releases and strict alternation
        rst_n = 0; set_all(20); set_t(1, 10); set_t(3, 30); cyc(1);
        rst_n = 1; cyc(60);
        // hysteresis band on zone 0
        rst_n = 0; set_all(20); set_t(0, 19); cyc(1);
        rst_n = 1; cyc(5); set_t(0, 18); cyc(1); set_t(0, 19); cyc(25);
        // enable drop mid-run, regrant, then reset mid-run
        rst_n = 0; set_all(20); set_t(0, 16); cyc(1);
        rst_n = 1; cyc(2); enable = 0; cyc(8);
        set_t(0, 20); set_t(2, 16); enable = 1; cyc(3);
        rst_n = 0; cyc(1); rst_n = 1; set_all(20); cyc(6);
        // temperature extremes
        set_t(1, 0); set_t(2, 31); cyc(45);
        // randomized traffic
        set_all(20);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) set_t($urandom_range(0, N - 1), rand_temp());
            enable = ($urandom_range(0, 31) != 0);
            rst_n  = ($urandom_range(0, 199) != 0);
            tick();
        end
        @(posedge clk);
        #2;
        if (vectors != pushed || vectors == 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d checked expected %0d", vectors, pushed);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
